// File: rtl/dram_mc.sv
// DRAM slave on the shared system bus: takes RD/WR frames, queues reads and answers
// each as a header plus LINE_BEATS data beats, in request order.

module dram_mc_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  // Word array indexed {line, beat}; no reset so contents survive rst.
  logic [DW-1:0] data [0:DEPTH-1];

  always_ff @(posedge clk) if (we) data[waddr] <= wdata;

  assign rdata = data[raddr];
endmodule

module dram_mc #(
  parameter int   BUS_DATA_WIDTH = 32,
  parameter int   CTRL_WIDTH     = 6,
  parameter int   BUS_WIDTH      = CTRL_WIDTH + BUS_DATA_WIDTH,
  parameter int   LINE_BEATS     = 4,
  parameter int   MEM_LINES      = 256,
  parameter int   QUEUE_DEPTH    = 4,
  parameter int   RD_LATENCY     = 3,
  parameter logic REQ_TYPE       = 1'b1
) (
  input  logic                         plusclk,
  input  logic                         rst,
  inout  wire  [BUS_WIDTH-1:0]         bus,
  input  logic                         bus_active,
  input  logic                         bus_grant,
  output logic                         bus_req,
  output logic                         bus_req_type,
  output logic [5:0]                   bus_req_clc,
  output logic [$clog2(QUEUE_DEPTH):0] q_count,
  output logic                         rd_ovf
);
  localparam int LB_W  = $clog2(LINE_BEATS);
  localparam int BW    = (LB_W > 0) ? LB_W : 1;
  localparam int LN_W  = $clog2(MEM_LINES);
  localparam int MA_W  = LN_W + LB_W;
  localparam int QP_W  = $clog2(QUEUE_DEPTH);
  localparam int QC_W  = QP_W + 1;
  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  typedef struct packed {
    logic [1:0]      src;
    logic [1:0]      pid;
    logic [LN_W-1:0] line;
  } qent_t;

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_WDATA, RX_DROP} rx_t;
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_REQ, TX_HDR, TX_DATA, TX_GAP} tx_t;

  function automatic logic [MA_W-1:0] idx(input logic [LN_W-1:0] ln, input logic [BW-1:0] bt);
    idx = (MA_W'(ln) << LB_W) | MA_W'(bt);
  endfunction

  // Bus field decode
  logic                      sample;
  logic [1:0]                b_src, b_pid, b_op;
  logic [LN_W-1:0]           b_line;
  logic [BUS_DATA_WIDTH-1:0] b_data;
  logic                      unused_bits;

  assign sample      = bus_active & ~bus_grant;
  assign b_src       = bus[BUS_DATA_WIDTH+4 +: 2];
  assign b_pid       = bus[BUS_DATA_WIDTH+2 +: 2];
  assign b_op        = bus[BUS_DATA_WIDTH   +: 2];
  assign b_data      = bus[BUS_DATA_WIDTH-1:0];
  assign b_line      = b_data[2+LB_W +: LN_W];
  assign unused_bits = ^bus;

  // RX FSM
  rx_t             rx_q;
  logic [1:0]      rsrc_q, rpid_q;
  logic            rwr_q;
  logic [LN_W-1:0] wline_q;
  logic [BW-1:0]   wbeat_q;

  always_ff @(posedge plusclk or negedge rst) begin
    if (!rst) begin
      rx_q    <= RX_IDLE;
      rsrc_q  <= '0;
      rpid_q  <= '0;
      rwr_q   <= 1'b0;
      wline_q <= '0;
      wbeat_q <= '0;
    end else begin
      case (rx_q)
        RX_IDLE: if (sample) begin
          if (!b_op[1]) begin
            rx_q   <= RX_ADDR;
            rsrc_q <= b_src;
            rpid_q <= b_pid;
            rwr_q  <= b_op[0];
          end else rx_q <= RX_DROP;
        end
        RX_ADDR: if (!bus_active) rx_q <= RX_IDLE;
          else if (sample) begin
            wline_q <= b_line;
            wbeat_q <= '0;
            rx_q    <= rwr_q ? RX_WDATA : RX_IDLE;
          end
        RX_WDATA: if (!bus_active) rx_q <= RX_IDLE;
          else if (sample) begin
            wbeat_q <= wbeat_q + BW'(1);
            if (wbeat_q == BW'(LINE_BEATS-1)) rx_q <= RX_IDLE;
          end
        RX_DROP: if (!bus_active) rx_q <= RX_IDLE;
        default: rx_q <= RX_IDLE;
      endcase
    end
  end

  // Read queue; the full test uses the pre-pop count so a same-cycle pop does not make room
  qent_t            q_mem [QUEUE_DEPTH];
  logic [QP_W-1:0]  wp_q, rp_q;
  logic [QC_W-1:0]  cnt_q, cnt_d;
  logic             ovf_q, rd_addr, q_full, enq, ovf_set, pop;
  qent_t            head;

  tx_t              tx_q;
  logic [LAT_W-1:0] lat_q;
  logic [BW-1:0]    tbeat_q;
  logic             req_q;

  assign rd_addr = (rx_q == RX_ADDR) && sample && !rwr_q;
  assign q_full  = (cnt_q == QC_W'(QUEUE_DEPTH));
  assign enq     = rd_addr && !q_full;
  assign ovf_set = rd_addr && q_full;
  assign pop     = (tx_q == TX_DATA) && bus_grant && (tbeat_q == BW'(LINE_BEATS-1));
  assign cnt_d   = cnt_q + QC_W'(enq) - QC_W'(pop);
  assign head    = q_mem[rp_q];

  always_ff @(posedge plusclk) if (enq) q_mem[wp_q] <= '{src: rsrc_q, pid: rpid_q, line: b_line};

  always_ff @(posedge plusclk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (enq)     wp_q  <= wp_q + QP_W'(1);
      if (pop)     rp_q  <= rp_q + QP_W'(1);
      if (ovf_set) ovf_q <= 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // TX FSM
  always_ff @(posedge plusclk or negedge rst) begin
    if (!rst) begin
      tx_q    <= TX_IDLE;
      lat_q   <= '0;
      tbeat_q <= '0;
      req_q   <= 1'b0;
    end else begin
      case (tx_q)
        TX_IDLE: if (cnt_q != '0) begin
          tx_q  <= TX_WAIT;
          lat_q <= '0;
        end
        TX_WAIT: if (lat_q == LAT_W'(RD_LATENCY-1)) begin
          tx_q  <= TX_REQ;
          req_q <= 1'b1;
        end else lat_q <= lat_q + LAT_W'(1);
        TX_REQ: if (bus_grant) begin
          tx_q  <= TX_HDR;
          req_q <= 1'b0;
        end
        TX_HDR: if (!bus_grant) tx_q <= TX_GAP;
          else begin
            tx_q    <= TX_DATA;
            tbeat_q <= '0;
          end
        TX_DATA: if (!bus_grant) tx_q <= TX_GAP;
          else if (pop) begin
            if (cnt_d != '0) begin
              tx_q  <= TX_WAIT;
              lat_q <= '0;
            end else tx_q <= TX_IDLE;
          end else tbeat_q <= tbeat_q + BW'(1);
        TX_GAP: begin
          tx_q  <= TX_REQ;
          req_q <= 1'b1;
        end
        default: tx_q <= TX_IDLE;
      endcase
    end
  end

  // Data is read combinationally at drive time so a just-committed write is visible
  logic [BUS_DATA_WIDTH-1:0] rdata, tx_data;
  logic                      drive;

  dram_mc_mem #(.DW(BUS_DATA_WIDTH), .DEPTH(MEM_LINES*LINE_BEATS), .AW(MA_W)) data_block (
    .clk  (plusclk),
    .we   ((rx_q == RX_WDATA) && sample),
    .waddr(idx(wline_q, wbeat_q)),
    .wdata(b_data),
    .raddr(idx(head.line, tbeat_q)),
    .rdata(rdata)
  );

  assign drive   = bus_grant && ((tx_q == TX_HDR) || (tx_q == TX_DATA));
  assign tx_data = (tx_q == TX_DATA) ? rdata : '0;
  assign bus     = drive ? {CTRL_WIDTH'({head.src, head.pid, 2'b10}), tx_data} : {BUS_WIDTH{1'bz}};

  assign bus_req      = req_q;
  assign bus_req_type = req_q ? REQ_TYPE : 1'b0;
  assign bus_req_clc  = req_q ? 6'(LINE_BEATS + 1) : 6'd0;
  assign q_count      = cnt_q;
  assign rd_ovf       = ovf_q;
endmodule

// File: tb/tb_dram_mc.sv
// Directed bench for dram_mc: latency, write/read, queue overflow, grant loss,
// reset mid-response, address aliasing and dropped RESP frames.

module tb_dram_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wire  [37:0] bus;
  logic [37:0] tb_bus;
  logic        tb_en;
  assign bus = tb_en ? tb_bus : 38'bz;

  logic       bus_active, bus_grant, bus_req, bus_req_type, rd_ovf;
  logic [5:0] bus_req_clc;
  logic [2:0] q_count;
  int tests = 0;
  int fails = 0;

  localparam logic [3:0][31:0] L1 = {32'hCCDDEEFF, 32'h9900AABB, 32'h55667788, 32'h11223344};
  localparam logic [3:0][31:0] L2 = {32'h3, 32'h2, 32'h1, 32'hDEADBEEF};

  dram_mc dut (
    .plusclk     (clk),
    .rst         (rst_n),
    .bus         (bus),
    .bus_active  (bus_active),
    .bus_grant   (bus_grant),
    .bus_req     (bus_req),
    .bus_req_type(bus_req_type),
    .bus_req_clc (bus_req_clc),
    .q_count     (q_count),
    .rd_ovf      (rd_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] c, input logic [31:0] d);
    tb_en = 1'b1; bus_active = 1'b1; tb_bus = {c, d};
  endtask

  task automatic idle();
    tb_en = 1'b0; bus_active = 1'b0;
  endtask

  // Released bus: the bench drives 0, which only reads back cleanly if the DUT is off the bus
  task automatic probe(input string tag);
    tb_bus = '0; tb_en = 1'b1;
    #1;
    check(tag, bus, 0);
    tb_en = 1'b0;
  endtask

  task automatic send_rd(input logic [5:0] c, input logic [31:0] a, input bit keep);
    drive(c, 32'h0); tick();
    drive(6'h0, a);  tick();
    if (!keep) idle();
  endtask

  task automatic send_wr(input logic [5:0] c, input logic [31:0] a, input logic [3:0][31:0] w);
    drive(c, 32'h0); tick();
    drive(6'h0, a);  tick();
    for (int i = 0; i < 4; i++) begin
      drive(6'h0, w[i]); tick();
    end
    idle();
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && bus_req !== 1'b1; i++) tick();
    check({tag, "_req"}, bus_req, 1);
    check({tag, "_clc"}, bus_req_clc, 5);
  endtask

  task automatic serve(input string tag, input logic [5:0] c, input logic [3:0][31:0] w,
                       input logic [2:0] qafter);
    wait_req(tag);
    tick(); bus_grant = 1'b1;
    tick();
    check({tag, "_hdr"}, bus, {c, 32'h0});
    check({tag, "_req_low"}, bus_req, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check({tag, "_beat"}, bus, {c, w[i]});
    end
    tick();
    probe({tag, "_release"});
    check({tag, "_qcnt"}, q_count, qafter);
    bus_grant = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tb_en = 1'b0; tb_bus = '0; bus_active = 1'b0; bus_grant = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", bus_req, 0);
    check("rst_type", bus_req_type, 0);
    check("rst_clc", bus_req_clc, 0);
    check("rst_qcnt", q_count, 0);
    check("rst_ovf", rd_ovf, 0);
    probe("rst_bus");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    send_wr(6'h01, 32'h10, L1);
    send_wr(6'h01, 32'h20, L2);
    check("wr_qcnt", q_count, 0);

    // Read latency: bus_req first high at A+RD_LATENCY+2
    send_rd(6'h18, 32'h10, 1'b0);
    check("lat_qcnt", q_count, 1);
    check("lat_a1", bus_req, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("lat_early", bus_req, 0);
    end
    tick();
    check("lat_a5", bus_req, 1);
    check("lat_type", bus_req_type, 1);
    serve("rd1", 6'h1A, L1, 3'd0);

    send_rd(6'h24, 32'h20, 1'b0);
    serve("wr_rd", 6'h26, L2, 3'd0);

    // Queue overflow with grant withheld
    for (int k = 0; k < 6; k++)
      send_rd({k[1:0], 4'b0000}, (k % 2) ? 32'h20 : 32'h10, 1'b1);
    idle();
    tick();
    check("full_qcnt", q_count, 4);
    check("full_ovf", rd_ovf, 1);
    for (int k = 0; k < 4; k++)
      serve("full", {k[1:0], 4'b0010}, (k % 2) ? L2 : L1, 3'(3 - k));
    repeat (10) tick();
    check("full_no_extra", bus_req, 0);

    // Grant loss mid-data
    send_rd(6'h18, 32'h10, 1'b0);
    wait_req("gd");
    tick(); bus_grant = 1'b1;
    tick(); check("gd_hdr", bus, {6'h1A, 32'h0});
    tick(); check("gd_b0", bus, {6'h1A, L1[0]});
    tick(); check("gd_b1", bus, {6'h1A, L1[1]});
    tick(); bus_grant = 1'b0;
    probe("gd_z");
    check("gd_qcnt", q_count, 1);
    tick(); check("gd_gap", bus_req, 0);
    tick(); check("gd_rereq", bus_req, 1);
    serve("gd_retry", 6'h1A, L1, 3'd0);

    // Reset during DATA
    send_rd(6'h24, 32'h20, 1'b0);
    wait_req("rm");
    tick(); bus_grant = 1'b1;
    tick(); check("rm_hdr", bus, {6'h26, 32'h0});
    tick(); check("rm_b0", bus, {6'h26, L2[0]});
    rst_n = 1'b0;
    #1;
    check("rm_req", bus_req, 0);
    check("rm_qcnt", q_count, 0);
    check("rm_ovf", rd_ovf, 0);
    probe("rm_bus");
    bus_grant = 1'b0;
    tick(); rst_n = 1'b1;
    tick();
    send_rd(6'h24, 32'h20, 1'b0);
    serve("rm_after", 6'h26, L2, 3'd0);

    // Alias: 0x1010 maps to line 1
    send_rd(6'h18, 32'h1010, 1'b0);
    serve("alias", 6'h1A, L1, 3'd0);

    // RESP-op frame is dropped whole, even if a later beat looks like a RD header
    drive(6'h02, 32'h0);  tick();
    drive(6'h18, 32'h0);  tick();
    drive(6'h00, 32'h10); tick();
    idle(); tick();
    check("drop_qcnt", q_count, 0);
    repeat (6) tick();
    check("drop_noreq", bus_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
